// File: rtl/aud_pkg.sv
// Shared types for the audio playback scheduler: FSM state encoding,
// default sample width and the signed sample type.
package aud_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } aud_state_t;

    localparam int AUD_DW = 16;

    typedef logic signed [AUD_DW-1:0] aud_sample_t;

endpackage

// File: rtl/aud_rr_arb.sv
// Combinational round-robin pick: first set request at or after i_ptr.
// Ports: i_req, i_ptr in; o_gnt (one-hot), o_idx, o_vld out.
module aud_rr_arb
    import aud_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [PW-1:0]    o_idx,
    output logic             o_vld
);

    int          s;
    logic [PW-1:0] j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        s     = 0;
        j     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s = int'(i_ptr) + i;
            if (s >= N_REQ) s = s - N_REQ;
            j = PW'(s);
            if (!o_vld && i_req[j]) begin
                o_vld    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = j;
            end
        end
    end

endmodule

// File: rtl/aud_play_sched.sv
// Frame-level owner scheduler for the shared I2S DAC player.
// Ports: i_clk, i_rst_n, i_lrc, i_req, i_valid, i_sample in;
// o_ack, o_grant, o_en, o_dac_data, o_underflow, o_state out.
// Option: AUD_SCHED_GAP_EN inserts one silent frame per handover.
module aud_play_sched
    import aud_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = AUD_DW,
    parameter int UF_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_lrc,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_valid,
    input  logic [N_REQ*DW-1:0] i_sample,
    output logic [N_REQ-1:0]   o_ack,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_en,
    output logic [DW-1:0]      o_dac_data,
    output logic [UF_W-1:0]    o_underflow,
    output logic [1:0]         o_state
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic lrc_s1, lrc_s2, lrc_d, lrc_fall;

    aud_state_t state, state_nxt;

    logic [N_REQ-1:0] grant, grant_nxt;
    logic [N_REQ-1:0] ack, ack_nxt;
    logic [PW-1:0]    own, own_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [DW-1:0]    data, data_nxt;
    logic [UF_W-1:0]  uf, uf_nxt;

    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic             arb_vld;

    logic          take, cons, drop;
    logic [PW-1:0] k;
    logic [DW-1:0] smp [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            smp[i] = i_sample[i*DW +: DW];
    end

    aud_rr_arb #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .i_req (i_req),
        .i_ptr (ptr),
        .o_gnt (arb_gnt),
        .o_idx (arb_idx),
        .o_vld (arb_vld)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrc_s1 <= 1'b0;
            lrc_s2 <= 1'b0;
            lrc_d  <= 1'b0;
        end else begin
            lrc_s1 <= i_lrc;
            lrc_s2 <= lrc_s1;
            lrc_d  <= lrc_s2;
        end
    end

    assign lrc_fall = lrc_d & ~lrc_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            grant <= '0;
            ack   <= '0;
            own   <= '0;
            ptr   <= '0;
            data  <= '0;
            uf    <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ack   <= ack_nxt;
            own   <= own_nxt;
            ptr   <= ptr_nxt;
            data  <= data_nxt;
            uf    <= uf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ack_nxt   = '0;
        own_nxt   = own;
        ptr_nxt   = ptr;
        data_nxt  = data;
        uf_nxt    = uf;
        take      = 1'b0;
        cons      = 1'b0;
        drop      = 1'b0;
        k         = own;

        if (lrc_fall) begin
            unique case (state)
                S_IDLE: take = arb_vld;
                S_RUN: begin
                    if (|(i_req & grant)) begin
                        cons = 1'b1;
                    end else if (arb_vld) begin
`ifdef AUD_SCHED_GAP_EN
                        state_nxt = S_GAP;
                        grant_nxt = '0;
                        data_nxt  = '0;
`else
                        take = 1'b1;
`endif
                    end else begin
                        drop = 1'b1;
                    end
                end
                S_GAP: begin
                    take = arb_vld;
                    drop = ~arb_vld;
                end
                default: drop = 1'b1;
            endcase
        end

        if (drop) begin
            state_nxt = S_IDLE;
            grant_nxt = '0;
            data_nxt  = '0;
        end

        // New owner: the pointer moves just past it so the
        // next handover starts searching at the following index.
        if (take) begin
            state_nxt = S_RUN;
            grant_nxt = arb_gnt;
            own_nxt   = arb_idx;
            ptr_nxt   = (arb_idx == PW'(N_REQ - 1)) ?
                        '0 : arb_idx + PW'(1);
            k         = arb_idx;
            cons      = 1'b1;
        end

        if (cons) begin
            if (i_valid[k]) begin
                data_nxt   = smp[k];
                ack_nxt[k] = 1'b1;
            end else begin
                data_nxt = '0;
                if (uf != {UF_W{1'b1}})
                    uf_nxt = uf + UF_W'(1);
            end
        end
    end

    assign o_ack       = ack;
    assign o_grant     = grant;
    assign o_en        = (state != S_IDLE);
    assign o_dac_data  = data;
    assign o_underflow = uf;
    assign o_state     = state;

endmodule

// File: tb/tb_aud_play_sched.sv
// Randomized bench for aud_play_sched against a frame-level model.
// Honors AUD_SCHED_GAP_EN the same way as the design.
module tb_aud_play_sched;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int UW = 8;
`ifdef AUD_SCHED_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          lrc   = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  valid = '0;
    logic [N*DW-1:0] smp = '0;

    logic [N-1:0]  o_ack;
    logic [N-1:0]  o_grant;
    logic          o_en;
    logic [DW-1:0] o_dac_data;
    logic [UW-1:0] o_underflow;
    logic [1:0]    o_state;

    aud_play_sched #(
        .N_REQ (N),
        .DW    (DW),
        .UF_W  (UW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_lrc       (lrc),
        .i_req       (req),
        .i_valid     (valid),
        .i_sample    (smp),
        .o_ack       (o_ack),
        .o_grant     (o_grant),
        .o_en        (o_en),
        .o_dac_data  (o_dac_data),
        .o_underflow (o_underflow),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    int            m_own;
    int            m_start;
    int            m_state;
    int            m_uf;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_ack;

    logic [38:0] obs;

    task automatic model_reset();
        m_own   = -1;
        m_start = 0;
        m_state = 0;
        m_uf    = 0;
        m_data  = '0;
        m_ack   = '0;
    endtask

    function automatic int rr_pick(logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (r[(m_start + i) % N]) return (m_start + i) % N;
        return -1;
    endfunction

    task automatic model_consume(int kk);
        if (valid[kk]) begin
            m_data = smp[kk*DW +: DW];
            m_ack  = N'(1) << kk;
        end else begin
            m_data = '0;
            if (m_uf < 255) m_uf++;
        end
    endtask

    task automatic model_frame();
        int p;
        m_ack = '0;
        if (m_own >= 0 && req[m_own]) begin
            model_consume(m_own);
        end else begin
            p = rr_pick(req);
            if (p < 0) begin
                m_own   = -1;
                m_state = 0;
                m_data  = '0;
            end else if (m_own >= 0 && GAP) begin
                m_own   = -1;
                m_state = 2;
                m_data  = '0;
            end else begin
                m_own   = p;
                m_start = (p + 1) % N;
                m_state = 1;
                model_consume(p);
            end
        end
    endtask

    function automatic logic [38:0] exp_vec();
        logic [N-1:0] g;
        g = (m_own >= 0) ? (N'(1) << m_own) : '0;
        return {2'(m_state), m_state != 0, g, m_ack,
                m_data, UW'(m_uf), 4'b0000};
    endfunction

    task automatic run_frame(logic [N-1:0] r,
                             logic [N-1:0] v,
                             logic [N*DW-1:0] s);
        @(negedge clk);
        req   = r;
        valid = v;
        smp   = s;
        lrc   = 1'b0;
        model_frame();
        repeat (3) @(posedge clk);
        #1;
        obs[38:4] = {o_state, o_en, o_grant, o_ack,
                     o_dac_data, o_underflow};
        @(posedge clk);
        #1;
        obs[3:0] = o_ack;
        @(negedge clk);
        lrc = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [N*DW-1:0] rnd_smp();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        lrc   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vec++;
        if ({o_state, o_en, o_grant, o_ack, o_dac_data,
             o_underflow} !== 35'd0) begin
            bad++;
            $display("FAIL reset: got %h want 0",
                     {o_state, o_en, o_grant, o_ack,
                      o_dac_data, o_underflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_first_grant();
        logic [N*DW-1:0] s;
        s = rnd_smp();
        s[DW-1:0] = 16'h1234;
        run_frame(4'b0001, 4'b1111, s);
        vec++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL first_grant: got %h want %h",
                     obs, exp_vec());
        end
        vec++;
        if (obs[27:12] !== 16'h1234) begin
            bad++;
            $display("FAIL first_data: got %h want 1234",
                     obs[27:12]);
        end
    endtask

    task automatic test_no_preempt();
        for (int f = 0; f < 4; f++) begin
            run_frame(4'b0011, 4'b0011, rnd_smp());
            vec++;
            if (obs !== exp_vec() || obs[35:32] !== 4'b0001) begin
                bad++;
                $display("FAIL no_preempt f%0d: got %h want %h",
                         f, obs, exp_vec());
            end
        end
    endtask

    task automatic test_handover();
        int nf;
        nf = GAP ? 2 : 1;
        for (int f = 0; f < nf; f++) begin
            run_frame(4'b1110, 4'b1110, rnd_smp());
            vec++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL handover f%0d: got %h want %h",
                         f, obs, exp_vec());
            end
        end
        vec++;
        if (obs[35:32] !== 4'b0010) begin
            bad++;
            $display("FAIL handover_grant: got %b want 0010",
                     obs[35:32]);
        end
    endtask

    task automatic test_underflow();
        for (int f = 0; f < 300; f++) begin
            run_frame(4'b0010, 4'b1101, rnd_smp());
            vec++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL underflow f%0d: got %h want %h",
                         f, obs, exp_vec());
            end
        end
        vec++;
        if (o_underflow !== 8'hff) begin
            bad++;
            $display("FAIL uf_sat: got %h want ff", o_underflow);
        end
    endtask

    task automatic test_idle();
        run_frame(4'b0000, 4'b1111, rnd_smp());
        vec++;
        if (obs !== exp_vec() || obs[36] !== 1'b0) begin
            bad++;
            $display("FAIL idle: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        r = '0;
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 1) == 0)
                r = 4'($urandom_range(0, 15));
            run_frame(r, 4'($urandom), rnd_smp());
            vec++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random f%0d: got %h want %h",
                         f, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        run_frame(4'b0100, 4'b0100, rnd_smp());
        vec++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL pre_reset: got %h want %h",
                     obs, exp_vec());
        end
        @(negedge clk);
        lrc = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if ({o_state, o_en, o_grant, o_ack, o_dac_data,
             o_underflow} !== 35'd0) begin
            bad++;
            $display("FAIL reset_mid: got %h want 0",
                     {o_state, o_en, o_grant, o_ack,
                      o_dac_data, o_underflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        lrc   = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        run_frame(4'b1111, 4'b1111, rnd_smp());
        vec++;
        if (obs !== exp_vec() || obs[35:32] !== 4'b0001) begin
            bad++;
            $display("FAIL post_reset: got %h want %h",
                     obs, exp_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_grant();
        test_no_preempt();
        test_handover();
        test_underflow();
        test_idle();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

endmodule
